// File: rtl/matmult_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : matmult_engine_if
// Brief    : Operand stream, result stream and status signals of the matrix
//            multiply engine, bundled with master (driver) and slave (engine)
//            views.
// Revision : 1.0 - initial release
// ============================================================================
interface matmult_engine_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
);
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic              calc_done;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, calc_done
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, calc_done
    );
endinterface
`default_nettype wire

// File: rtl/matmult_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmult_engine
// Brief    : Streams in two NxN matrices A and B (row-major, A first),
//            computes C = A x B with one multiply-accumulate per cycle and
//            streams C out row-major over a valid/ready handshake.
//            Build option: define MATMULT_SIGNED_EN for two's complement
//            operands/results; undefined gives unsigned arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module matmult_engine #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  wire logic       sys_clk,
    input  wire logic       rst,
    matmult_engine_if.slave bus
);

    localparam int unsigned c_N2   = N * N;
    localparam int unsigned c_NOPS = 2 * N * N;
    localparam int unsigned c_EW   = $clog2(c_NOPS);
    localparam int unsigned c_CW   = $clog2(c_N2);
    localparam int unsigned c_IW   = $clog2(N);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOAD    = 2'd1;
    localparam logic [1:0] c_ST_COMPUTE = 2'd2;
    localparam logic [1:0] c_ST_OUTPUT  = 2'd3;

    // Parameter sanity checks at elaboration
    generate
        if (N < 2 || N > 4) begin : g_bad_n
            $error("matmult_engine: N must lie in 2..4");
        end
        if (ACC_W < 2 * DATA_W + $clog2(N)) begin : g_bad_acc_w
            $error("matmult_engine: ACC_W too small for 2*DATA_W+clog2(N)");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_EW-1:0]   r_elem_cnt;
    logic [c_IW-1:0]   r_i;
    logic [c_IW-1:0]   r_j;
    logic [c_IW-1:0]   r_k;
    logic [c_CW-1:0]   r_out_idx;
    logic [ACC_W-1:0]  r_acc;
    logic              r_calc_done;

    // Operand store: A at 0..N*N-1, B at N*N..2*N*N-1. Not reset; results are
    // only ever shown in OUTPUT, which is reachable only after a full load.
    logic [DATA_W-1:0] r_op [0:c_NOPS-1];
    logic [ACC_W-1:0]  r_c  [0:c_N2-1];

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_last_elem;
    logic              w_last_mac;
    logic              w_last_out;
    logic [c_EW-1:0]   w_a_idx;
    logic [c_EW-1:0]   w_b_idx;
    logic [c_CW-1:0]   w_c_idx;
    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]  w_sum;

    // Widen an operand to accumulator width (sign- or zero-extension by build)
    function automatic logic [ACC_W-1:0] f_ext(input logic [DATA_W-1:0] x);
`ifdef MATMULT_SIGNED_EN
        return {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
`else
        return {{(ACC_W - DATA_W){1'b0}}, x};
`endif
    endfunction

    assign w_in_xfer   = bus.in_valid & w_in_ready;
    assign w_out_xfer  = w_out_valid & bus.out_ready;
    assign w_last_elem = (r_elem_cnt == c_EW'(c_NOPS - 1));
    assign w_last_mac  = (r_i == c_IW'(N - 1)) && (r_j == c_IW'(N - 1)) &&
                         (r_k == c_IW'(N - 1));
    assign w_last_out  = (r_out_idx == c_CW'(c_N2 - 1));

    assign w_a_idx = c_EW'(r_i) * c_EW'(N) + c_EW'(r_k);
    assign w_b_idx = c_EW'(c_N2) + c_EW'(r_k) * c_EW'(N) + c_EW'(r_j);
    assign w_c_idx = c_CW'(r_i) * c_CW'(N) + c_CW'(r_j);

    // Low ACC_W bits of the product of extended operands are exact modulo
    // 2^ACC_W in both signed and unsigned builds.
    assign w_prod = f_ext(r_op[w_a_idx]) * f_ext(r_op[w_b_idx]);
    assign w_sum  = ((r_k == '0) ? '0 : r_acc) + w_prod;

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (w_in_xfer) w_state_nxt = c_ST_LOAD;
                c_ST_LOAD:    if (w_in_xfer && w_last_elem) w_state_nxt = c_ST_COMPUTE;
                c_ST_COMPUTE: if (w_last_mac) w_state_nxt = c_ST_OUTPUT;
                c_ST_OUTPUT:  if (w_out_xfer && w_last_out) w_state_nxt = c_ST_IDLE;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; in_ready is also held low while reset is active
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_in_ready = ~rst;
            end
            c_ST_LOAD: begin
                w_in_ready = ~rst;
                w_busy     = 1'b1;
            end
            c_ST_COMPUTE: begin
                w_busy     = 1'b1;
            end
            c_ST_OUTPUT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
            end
            default: begin
                w_busy     = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.calc_done = r_calc_done;
    assign bus.out_data  = r_c[r_out_idx];

    // Element, loop and output counters, accumulator and done pulse
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_elem_cnt  <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_out_idx   <= '0;
            r_acc       <= '0;
            r_calc_done <= 1'b0;
        end else if (bus.clear) begin
            r_elem_cnt  <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_out_idx   <= '0;
            r_acc       <= '0;
            r_calc_done <= 1'b0;
        end else begin
            r_calc_done <= (r_state == c_ST_COMPUTE) && w_last_mac;
            case (r_state)
                c_ST_IDLE, c_ST_LOAD: begin
                    if (w_in_xfer) begin
                        r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + c_EW'(1);
                    end
                end
                c_ST_COMPUTE: begin
                    r_acc <= w_sum;
                    if (r_k == c_IW'(N - 1)) begin
                        r_k <= '0;
                        if (r_j == c_IW'(N - 1)) begin
                            r_j <= '0;
                            r_i <= (r_i == c_IW'(N - 1)) ? '0 : r_i + c_IW'(1);
                        end else begin
                            r_j <= r_j + c_IW'(1);
                        end
                    end else begin
                        r_k <= r_k + c_IW'(1);
                    end
                end
                c_ST_OUTPUT: begin
                    if (w_out_xfer) begin
                        r_out_idx <= w_last_out ? '0 : r_out_idx + c_CW'(1);
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // Operand and result storage writes (no reset on data arrays)
    always_ff @(posedge sys_clk) begin
        if (!bus.clear && w_in_xfer) begin
            r_op[r_elem_cnt] <= bus.in_data;
        end
        if (!bus.clear && (r_state == c_ST_COMPUTE) && (r_k == c_IW'(N - 1))) begin
            r_c[w_c_idx] <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmult_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmult_engine
// Brief    : Directed self-checking bench for matmult_engine (N=2, DATA_W=8,
//            ACC_W=18) with hand-computed expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmult_engine;

    logic sys_clk;
    logic rst;
    int   total;
    int   bad;
    int   xfer_cnt;

    matmult_engine_if #(.DATA_W(8), .ACC_W(18)) bus ();

    matmult_engine #(.N(2), .DATA_W(8), .ACC_W(18)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count every result transfer seen on a rising edge
    initial xfer_cnt = 0;
    always @(posedge sys_clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream n elements (first n bytes of v, most significant first)
    task automatic load_elems(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = v[63 - 8 * i -: 8];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for calc_done; returns cycles spent in COMPUTE
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.calc_done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Drain four results, optionally stalling 5 cycles before each transfer
    task automatic read_results(input string tag, input int e0, input int e1,
                                input int e2, input int e3, input bit stall);
        int e[4];
        int base;
        int w;
        e    = '{e0, e1, e2, e3};
        base = xfer_cnt;
        for (int k = 0; k < 4; k++) begin
            if (stall) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
                    chk({tag, "_stall_data"}, 32'(bus.out_data), 32'(e[k]));
                    tick();
                end
            end
            bus.out_ready = 1'b1;
            w = 0;
            while (bus.out_valid !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            chk({tag, "_data"}, 32'(bus.out_data), 32'(e[k]));
            tick();
            if (k == 0) chk({tag, "_done_pulse"}, 32'(bus.calc_done), 32'd0);
        end
        bus.out_ready = 1'b0;
        chk({tag, "_end_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_xfers"}, 32'(xfer_cnt - base), 32'd4);
    endtask

    // Full job with latency check
    task automatic run_job(input string tag, input logic [63:0] v, input int e0,
                           input int e1, input int e2, input int e3, input bit stall);
        int cyc;
        load_elems(v, 8);
        chk({tag, "_busy_compute"}, 32'(bus.busy), 32'd1);
        chk({tag, "_ready_compute"}, 32'(bus.in_ready), 32'd0);
        wait_done(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        read_results(tag, e0, e1, e2, e3, stall);
    endtask

    initial begin
        int cyc;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_calc_done", 32'(bus.calc_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic job
        run_job("basic", 64'h0102_0304_0506_0708, 19, 22, 43, 50, 1'b0);

        // All 0xFF operands
`ifdef MATMULT_SIGNED_EN
        run_job("allff", 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 2, 2, 1'b0);
`else
        run_job("allff", 64'hFFFF_FFFF_FFFF_FFFF, 32'h1FC02, 32'h1FC02, 32'h1FC02, 32'h1FC02, 1'b0);
`endif

        // A all 0xFF, B all 0x01
`ifdef MATMULT_SIGNED_EN
        run_job("ff_x_1", 64'hFFFF_FFFF_0101_0101, 32'h3FFFE, 32'h3FFFE, 32'h3FFFE, 32'h3FFFE, 1'b0);
`else
        run_job("ff_x_1", 64'hFFFF_FFFF_0101_0101, 32'h1FE, 32'h1FE, 32'h1FE, 32'h1FE, 1'b0);
`endif

        // Backpressure on every output
        run_job("bp", 64'h0102_0304_0506_0708, 19, 22, 43, 50, 1'b1);

        // Abort during load, then a full job with stray in_valid pulses
        load_elems(64'h0909_0909_0000_0000, 3);
        chk("abort_busy_load", 32'(bus.busy), 32'd1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        load_elems(64'h0102_0304_0506_0708, 8);
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        tick();
        chk("abort_ready_compute", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_done(cyc);
        chk("abort_latency", 32'(cyc + 3), 32'd8);
        // Input offered throughout the output phase, including the final transfer
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        read_results("abort", 19, 22, 43, 50, 1'b0);
        bus.in_valid = 1'b0;

        // Reset mid-compute, asserted between clock edges
        load_elems(64'h0102_0304_0506_0708, 8);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge sys_clk);
        #3;
        rst = 1'b0;
        tick();
        chk("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
        run_job("after_rst", 64'h0102_0304_0506_0708, 19, 22, 43, 50, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
